// File: rtl/spad_vec_sched_if.sv
// Bundle of handshake and port-B signals for spad_vec_sched.
// slave  : the scheduler (drives command/data ready, read data, port-B controls)
// master : the requesters plus the scratchpad port-B read return
interface spad_vec_sched_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 8,
    parameter int LEN_WIDTH  = 11
);
    localparam int ROW_W = ADDR_WIDTH - 3;
    localparam int VEC_W = NUM_BANKS * DATA_WIDTH;

    // Vector reader
    logic                  rd_cmd_valid;
    logic                  rd_cmd_ready;
    logic [ROW_W-1:0]      rd_cmd_row;
    logic [LEN_WIDTH-1:0]  rd_cmd_len;
    logic                  rd_data_valid;
    logic                  rd_data_ready;
    logic [VEC_W-1:0]      rd_data;

    // Vector writer
    logic                  wr_cmd_valid;
    logic                  wr_cmd_ready;
    logic [ROW_W-1:0]      wr_cmd_row;
    logic [LEN_WIDTH-1:0]  wr_cmd_len;
    logic                  wr_data_valid;
    logic                  wr_data_ready;
    logic [VEC_W-1:0]      wr_data;
    logic [NUM_BANKS-1:0]  wr_strb;

    // Scratchpad wide port B
    logic [ADDR_WIDTH-1:0] sp_addr;
    logic [VEC_W-1:0]      sp_din;
    logic [VEC_W-1:0]      sp_dout;
    logic                  sp_en;
    logic [NUM_BANKS-1:0]  sp_we;

    modport slave (
        input  rd_cmd_valid, rd_cmd_row, rd_cmd_len, rd_data_ready,
        output rd_cmd_ready, rd_data_valid, rd_data,
        input  wr_cmd_valid, wr_cmd_row, wr_cmd_len, wr_data_valid, wr_data, wr_strb,
        output wr_cmd_ready, wr_data_ready,
        input  sp_dout,
        output sp_addr, sp_din, sp_en, sp_we
    );

    modport master (
        output rd_cmd_valid, rd_cmd_row, rd_cmd_len, rd_data_ready,
        input  rd_cmd_ready, rd_data_valid, rd_data,
        output wr_cmd_valid, wr_cmd_row, wr_cmd_len, wr_data_valid, wr_data, wr_strb,
        input  wr_cmd_ready, wr_data_ready,
        output sp_dout,
        input  sp_addr, sp_din, sp_en, sp_we
    );
endinterface

// File: rtl/spad_vec_sched.sv
// spad_vec_sched: schedules read/write row bursts from two requesters onto
// the scratchpad wide port B. Reads go through a 2-entry return FIFO that
// absorbs the 1-cycle port-B read latency under reader backpressure.
// Optional feature macro: SPAD_SCHED_PERF_EN (saturating perf counters;
// when undefined the perf ports are tied to zero).
module spad_vec_sched #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 8,
    parameter int LEN_WIDTH  = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    spad_vec_sched_if.slave    bus,
    output logic               busy,
    output logic               done,
    output logic               done_is_wr,
    output logic [31:0]        perf_rd_rows,
    output logic [31:0]        perf_wr_rows,
    output logic [31:0]        perf_stall_cycles
);
    localparam int ROW_W = ADDR_WIDTH - 3;
    localparam int VEC_W = NUM_BANKS * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t               state_reg;
    logic                 last_grant_wr_reg;
    logic [ROW_W-1:0]     cur_row_reg;
    logic [LEN_WIDTH-1:0] rows_left_reg;
    logic                 done_reg;
    logic                 done_is_wr_reg;

    logic                 inflight_reg;
    logic [VEC_W-1:0]     fifo_mem [2];
    logic                 fifo_wr_ptr_reg;
    logic                 fifo_rd_ptr_reg;
    logic [1:0]           fifo_count_reg;
    logic [1:0]           fifo_count_next;
    logic [1:0]           occupancy;

    logic grant_rd, grant_wr;
    logic rd_pop, rd_push, rd_issue, rd_finish;
    logic wr_active, wr_hs, wr_finish;

    // Arbitration: a lone requester wins; on contention the one not granted last wins.
    assign grant_rd = (state_reg == IDLE) && bus.rd_cmd_valid &&
                      (!bus.wr_cmd_valid || last_grant_wr_reg);
    assign grant_wr = (state_reg == IDLE) && bus.wr_cmd_valid &&
                      (!bus.rd_cmd_valid || !last_grant_wr_reg);
    assign bus.rd_cmd_ready = grant_rd;
    assign bus.wr_cmd_ready = grant_wr;

    // Read path: a new row may be issued only if its return has a FIFO slot,
    // counting the slot freed by a pop in this same cycle.
    assign occupancy       = fifo_count_reg + {1'b0, inflight_reg};
    assign rd_pop          = (fifo_count_reg != 2'd0) && bus.rd_data_ready;
    assign rd_push         = inflight_reg;
    assign rd_issue        = (state_reg == RD) && (rows_left_reg != '0) &&
                             ((occupancy < 2'd2) || rd_pop);
    assign fifo_count_next = fifo_count_reg + {1'b0, rd_push} - {1'b0, rd_pop};
    assign rd_finish       = (state_reg == RD) && (rows_left_reg == '0) &&
                             !inflight_reg && (fifo_count_next == 2'd0);

    assign bus.rd_data_valid = (fifo_count_reg != 2'd0);
    assign bus.rd_data       = bus.rd_data_valid ? fifo_mem[fifo_rd_ptr_reg] : '0;

    // Write path: a beat goes straight to port B in its handshake cycle.
    assign wr_active         = (state_reg == WR) && (rows_left_reg != '0);
    assign bus.wr_data_ready = wr_active;
    assign wr_hs             = wr_active && bus.wr_data_valid;
    assign wr_finish         = wr_hs && (rows_left_reg == LEN_WIDTH'(1));

    // Port B is quiet (all zero) whenever nothing is issued.
    assign bus.sp_en   = rd_issue || wr_hs;
    assign bus.sp_we   = wr_hs ? bus.wr_strb : '0;
    assign bus.sp_addr = bus.sp_en ? {cur_row_reg, 3'b000} : '0;
    assign bus.sp_din  = wr_hs ? bus.wr_data : '0;

    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign done_is_wr = done_is_wr_reg;

    // Burst FSM: grant, row sequencing and registered completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            last_grant_wr_reg <= 1'b1;
            cur_row_reg       <= '0;
            rows_left_reg     <= '0;
            done_reg          <= 1'b0;
            done_is_wr_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_rd) begin
                        last_grant_wr_reg <= 1'b0;
                        cur_row_reg       <= bus.rd_cmd_row;
                        rows_left_reg     <= bus.rd_cmd_len;
                        if (bus.rd_cmd_len == '0) begin
                            done_reg       <= 1'b1;
                            done_is_wr_reg <= 1'b0;
                        end else begin
                            state_reg <= RD;
                        end
                    end else if (grant_wr) begin
                        last_grant_wr_reg <= 1'b1;
                        cur_row_reg       <= bus.wr_cmd_row;
                        rows_left_reg     <= bus.wr_cmd_len;
                        if (bus.wr_cmd_len == '0) begin
                            done_reg       <= 1'b1;
                            done_is_wr_reg <= 1'b1;
                        end else begin
                            state_reg <= WR;
                        end
                    end
                end
                RD: begin
                    if (rd_issue) begin
                        cur_row_reg   <= cur_row_reg + 1'b1;
                        rows_left_reg <= rows_left_reg - 1'b1;
                    end
                    if (rd_finish) begin
                        state_reg      <= IDLE;
                        done_reg       <= 1'b1;
                        done_is_wr_reg <= 1'b0;
                    end
                end
                WR: begin
                    if (wr_hs) begin
                        cur_row_reg   <= cur_row_reg + 1'b1;
                        rows_left_reg <= rows_left_reg - 1'b1;
                    end
                    if (wr_finish) begin
                        state_reg      <= IDLE;
                        done_reg       <= 1'b1;
                        done_is_wr_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Return FIFO control: in-flight flag and pointers; reset drops any pending return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg    <= 1'b0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_count_reg  <= 2'd0;
        end else begin
            inflight_reg   <= rd_issue;
            fifo_count_reg <= fifo_count_next;
            if (rd_push) begin
                fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            end
            if (rd_pop) begin
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            end
        end
    end

    // Return FIFO storage: capture port-B read data the cycle after issue.
    always_ff @(posedge clk) begin
        if (rd_push) begin
            fifo_mem[fifo_wr_ptr_reg] <= bus.sp_dout;
        end
    end

`ifdef SPAD_SCHED_PERF_EN
    logic [2:0]  perf_inc;
    logic [31:0] perf_cnt_reg [3];

    assign perf_inc[0] = bus.rd_data_valid && bus.rd_data_ready;
    assign perf_inc[1] = wr_hs;
    assign perf_inc[2] = ((state_reg == RD) && bus.rd_data_valid && !bus.rd_data_ready) ||
                         ((state_reg == WR) && !bus.wr_data_valid);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_perf
            // Saturating event counter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    perf_cnt_reg[gi] <= '0;
                end else if (perf_inc[gi] && (perf_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign perf_rd_rows      = perf_cnt_reg[0];
    assign perf_wr_rows      = perf_cnt_reg[1];
    assign perf_stall_cycles = perf_cnt_reg[2];
`else
    assign perf_rd_rows      = '0;
    assign perf_wr_rows      = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_spad_vec_sched.sv
// Scoreboard bench for spad_vec_sched: stimulus pushes expected port-B
// events, read vectors, grants and done pulses; a monitor compares them.
`timescale 1ns/1ps
module tb_spad_vec_sched;
    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_BANKS  = 8;
    localparam int LEN_WIDTH  = 11;
    localparam int VEC_W      = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spad_vec_sched_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                        .NUM_BANKS(NUM_BANKS), .LEN_WIDTH(LEN_WIDTH)) bus ();

    logic        busy, done, done_is_wr;
    logic [31:0] perf_rd_rows, perf_wr_rows, perf_stall_cycles;

    spad_vec_sched #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
                     .NUM_BANKS(NUM_BANKS), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .done(done),
        .done_is_wr(done_is_wr),
        .perf_rd_rows(perf_rd_rows),
        .perf_wr_rows(perf_wr_rows),
        .perf_stall_cycles(perf_stall_cycles)
    );

    typedef struct packed {
        logic [7:0]       we;
        logic [12:0]      addr;
        logic [VEC_W-1:0] din;
    } sp_ev_t;

    typedef struct packed {
        logic [VEC_W-1:0] data;
        logic [7:0]       strb;
    } wbeat_t;

    logic [VEC_W-1:0] exp_rd [$];
    sp_ev_t           exp_sp [$];
    bit               exp_done [$];
    bit               exp_grant [$];
    wbeat_t           wr_q [$];

    int errors = 0;
    int checks = 0;
    int issued = 0;
    int delivered = 0;
    int rdy_mode = 0;

    logic [VEC_W-1:0] mem [1024];

    function automatic logic [VEC_W-1:0] pat(int r);
        logic [VEC_W-1:0] v;
        for (int b = 0; b < 8; b++) begin
            v[b*32 +: 32] = (32'(r) * 32'h11) | (32'(b) << 24);
        end
        return v;
    endfunction

    task automatic chk(string name, logic [VEC_W-1:0] act, logic [VEC_W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    // Scratchpad port-B model: registered read, per-bank write.
    initial begin
        for (int r = 0; r < 1024; r++) mem[r] = pat(r);
        bus.sp_dout = '0;
    end
    always @(posedge clk) begin
        if (bus.sp_en) begin
            if (bus.sp_we == 8'h00) begin
                bus.sp_dout <= mem[bus.sp_addr[12:3]];
            end else begin
                for (int b = 0; b < 8; b++) begin
                    if (bus.sp_we[b]) mem[bus.sp_addr[12:3]][b*32 +: 32] <= bus.sp_din[b*32 +: 32];
                end
            end
        end
    end

    // Reader ready: constant 1 or the 1,0,0,1 pattern.
    initial begin
        bit rdy_pat [4];
        int k;
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        k = 0;
        bus.rd_data_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                bus.rd_data_ready = rdy_pat[k % 4];
                k++;
            end else begin
                bus.rd_data_ready = 1'b1;
                k = 0;
            end
        end
    end

    // Writer data driver: offers queued beats, pops on handshake.
    initial begin
        bit hs;
        bus.wr_data_valid = 1'b0;
        bus.wr_data = '0;
        bus.wr_strb = '0;
        forever begin
            @(negedge clk);
            hs = bus.wr_data_valid && bus.wr_data_ready;
            @(posedge clk);
            #1;
            if (hs && wr_q.size() != 0) void'(wr_q.pop_front());
            if (wr_q.size() != 0) begin
                bus.wr_data_valid = 1'b1;
                bus.wr_data = wr_q[0].data;
                bus.wr_strb = wr_q[0].strb;
            end else begin
                bus.wr_data_valid = 1'b0;
                bus.wr_data = '0;
                bus.wr_strb = '0;
            end
        end
    end

    // Monitor: compares every DUT output event against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.rd_cmd_ready || bus.wr_cmd_ready) begin
                    chk("one_grant", VEC_W'(bus.rd_cmd_ready && bus.wr_cmd_ready), '0);
                    if (exp_grant.size() == 0) fail_now("grant");
                    else chk("grant_is_wr", VEC_W'(bus.wr_cmd_ready), VEC_W'(exp_grant.pop_front()));
                end
                if (bus.rd_data_valid && bus.rd_data_ready) begin
                    delivered++;
                    if (exp_rd.size() == 0) fail_now("rd_data");
                    else chk("rd_data", bus.rd_data, exp_rd.pop_front());
                end
                if (bus.sp_en) begin
                    if (exp_sp.size() == 0) begin
                        fail_now("sp_en");
                    end else begin
                        sp_ev_t e;
                        e = exp_sp.pop_front();
                        chk("sp_addr", VEC_W'(bus.sp_addr), VEC_W'(e.addr));
                        chk("sp_we", VEC_W'(bus.sp_we), VEC_W'(e.we));
                        chk("sp_din", bus.sp_din, e.din);
                    end
                    if (bus.sp_we == 8'h00) begin
                        issued++;
                        chk("outstanding_over_2", VEC_W'((issued - delivered) > 2), '0);
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) fail_now("done");
                    else chk("done_is_wr", VEC_W'(done_is_wr), VEC_W'(exp_done.pop_front()));
                end
            end
        end
    end

    task automatic exp_read_row(int r, logic [VEC_W-1:0] d);
        sp_ev_t e;
        e.we = 8'h00;
        e.addr = 13'((r % 1024) * 8);
        e.din = '0;
        exp_sp.push_back(e);
        exp_rd.push_back(d);
    endtask

    task automatic exp_read_burst(int row, int len);
        for (int i = 0; i < len; i++) exp_read_row((row + i) % 1024, pat((row + i) % 1024));
    endtask

    task automatic exp_write_beat(int r, logic [VEC_W-1:0] d, logic [7:0] s);
        sp_ev_t e;
        wbeat_t w;
        e.we = s;
        e.addr = 13'((r % 1024) * 8);
        e.din = d;
        exp_sp.push_back(e);
        w.data = d;
        w.strb = s;
        wr_q.push_back(w);
    endtask

    task automatic send_rd(int row, int len);
        bit got;
        got = 1'b0;
        bus.rd_cmd_row = 10'(row);
        bus.rd_cmd_len = 11'(len);
        bus.rd_cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.rd_cmd_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rd_cmd_timeout: got no ready expected ready");
        end
        @(posedge clk);
        #1;
        bus.rd_cmd_valid = 1'b0;
    endtask

    task automatic send_wr(int row, int len);
        bit got;
        got = 1'b0;
        bus.wr_cmd_row = 10'(row);
        bus.wr_cmd_len = 11'(len);
        bus.wr_cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (bus.wr_cmd_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wr_cmd_timeout: got no ready expected ready");
        end
        @(posedge clk);
        #1;
        bus.wr_cmd_valid = 1'b0;
    endtask

    task automatic drain(string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (exp_sp.size() == 0 && exp_rd.size() == 0 && exp_done.size() == 0 &&
                exp_grant.size() == 0 && wr_q.size() == 0 && !busy) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_drain: got sp=%0d rd=%0d done=%0d grant=%0d pending expected 0", name,
                     exp_sp.size(), exp_rd.size(), exp_done.size(), exp_grant.size());
        end else begin
            $display("txn %s complete", name);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [VEC_W-1:0] d1, d2, rb0;
        bus.rd_cmd_valid = 1'b0;
        bus.rd_cmd_row = '0;
        bus.rd_cmd_len = '0;
        bus.wr_cmd_valid = 1'b0;
        bus.wr_cmd_row = '0;
        bus.wr_cmd_len = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", VEC_W'({busy, done, done_is_wr, bus.sp_en, bus.sp_we, bus.rd_data_valid,
                                     bus.wr_data_ready, bus.sp_addr}), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Contention chain out of reset: RD, WR, RD, WR
        exp_grant.push_back(1'b0);
        exp_grant.push_back(1'b1);
        exp_grant.push_back(1'b0);
        exp_grant.push_back(1'b1);
        exp_read_burst(10, 2);
        exp_done.push_back(1'b0);
        exp_write_beat(300, {8{32'hB00B_0300}}, 8'hFF);
        exp_done.push_back(1'b1);
        exp_read_burst(20, 3);
        exp_done.push_back(1'b0);
        exp_write_beat(310, {8{32'h0D0D_0310}}, 8'hF0);
        exp_write_beat(311, {8{32'h0D0D_0311}}, 8'h3C);
        exp_done.push_back(1'b1);
        fork
            begin
                send_rd(10, 2);
                send_rd(20, 3);
            end
            begin
                send_wr(300, 1);
                send_wr(310, 2);
            end
        join
        drain("contention");

        // Read row 5 len 4 with latency checks
        exp_grant.push_back(1'b0);
        exp_read_burst(5, 4);
        exp_done.push_back(1'b0);
        send_rd(5, 4);
        @(negedge clk);
        chk("rd_first_issue", VEC_W'({bus.sp_en, bus.sp_addr}), VEC_W'({1'b1, 13'd40}));
        chk("rd_valid_T1", VEC_W'(bus.rd_data_valid), '0);
        @(negedge clk);
        chk("rd_valid_T2", VEC_W'(bus.rd_data_valid), '0);
        @(negedge clk);
        chk("rd_valid_T3", VEC_W'(bus.rd_data_valid), VEC_W'(1'b1));
        drain("read_row5_len4");

        // Write row 1023 len 2 with wrap and partial strobe
        d1 = {8{32'hCAFE_0001}};
        for (int b = 0; b < 8; b++) d2[b*32 +: 32] = 32'hD200_0000 + 32'(b);
        exp_grant.push_back(1'b1);
        exp_write_beat(1023, d1, 8'hFF);
        exp_write_beat(0, d2, 8'h0F);
        exp_done.push_back(1'b1);
        send_wr(1023, 2);
        drain("write_wrap");

        // Read back across the wrap: row 0 keeps banks 4..7 of the original pattern
        rb0 = pat(0);
        for (int b = 0; b < 4; b++) rb0[b*32 +: 32] = d2[b*32 +: 32];
        exp_grant.push_back(1'b0);
        exp_read_row(1023, d1);
        exp_read_row(0, rb0);
        exp_done.push_back(1'b0);
        send_rd(1023, 2);
        drain("readback_wrap");

        // Read len 6 under toggling backpressure
        rdy_mode = 1;
        exp_grant.push_back(1'b0);
        exp_read_burst(200, 6);
        exp_done.push_back(1'b0);
        send_rd(200, 6);
        drain("read_backpressure");
        rdy_mode = 0;

        // Zero-length write: no port-B access, done one cycle after acceptance
        exp_grant.push_back(1'b1);
        exp_done.push_back(1'b1);
        send_wr(500, 0);
        @(negedge clk);
        chk("len0_done", VEC_W'({done, done_is_wr}), VEC_W'(2'b11));
        @(negedge clk);
        chk("len0_done_single", VEC_W'(done), '0);
        drain("write_len0");

        // Reset during row 2 of an 8-row read
        exp_grant.push_back(1'b0);
        exp_read_burst(100, 8);
        send_rd(100, 8);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_sp.delete();
        exp_rd.delete();
        issued = 0;
        delivered = 0;
        @(negedge clk);
        chk("rst_mid_burst", VEC_W'({busy, bus.rd_data_valid, done, bus.sp_en}), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_idle", VEC_W'({busy, bus.rd_data_valid, done}), '0);
        @(posedge clk);
        #1;
        exp_grant.push_back(1'b0);
        exp_read_burst(50, 1);
        exp_done.push_back(1'b0);
        send_rd(50, 1);
        drain("read_after_reset");

`ifndef SPAD_SCHED_PERF_EN
        chk("perf_tied_zero", VEC_W'({perf_rd_rows, perf_wr_rows, perf_stall_cycles}), '0);
`else
        chk("perf_counts", VEC_W'({perf_rd_rows, perf_wr_rows, perf_stall_cycles}),
            VEC_W'({32'd1, 32'd0, 32'd0}));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spad_vec_sched.md
Name: spad_vec_sched

Overview:
- Compute-side scheduler for the 8-bank scratchpad's wide port B: 256-bit vectors, one 8-word row per access.
- Arbitrates between two requesters: a vector reader (operand fetch) and a vector writer (result writeback).
- Each command is a burst of consecutive rows. The block sequences it row by row onto port B, handles the 1-cycle read latency with a 2-entry return FIFO, and exposes valid/ready streams to the requesters.

Parameters:
ADDR_WIDTH, 13, scratchpad word-address width; rows are addressed by ADDR_WIDTH-3 bits (ROW_W, localparam)
DATA_WIDTH, 32, bank word width
NUM_BANKS, 8, banks per row; VEC_W = NUM_BANKS*DATA_WIDTH (localparam)
LEN_WIDTH, 11, burst-length field width (rows)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_cmd_valid  in  1  read burst request
rd_cmd_ready  out  1  read command accepted this cycle
rd_cmd_row  in  ROW_W  first row of read burst
rd_cmd_len  in  LEN_WIDTH  rows to read
rd_data_valid  out  1  read vector available
rd_data_ready  in  1  reader accepts vector
rd_data  out  VEC_W  read vector
wr_cmd_valid  in  1  write burst request
wr_cmd_ready  out  1  write command accepted this cycle
wr_cmd_row  in  ROW_W  first row of write burst
wr_cmd_len  in  LEN_WIDTH  rows to write
wr_data_valid  in  1  write vector offered
wr_data_ready  out  1  write vector accepted
wr_data  in  VEC_W  write vector
wr_strb  in  NUM_BANKS  per-bank write enable for the vector
sp_addr  out  ADDR_WIDTH  port-B address = {row, 3'b000}
sp_din  out  VEC_W  port-B write data
sp_dout  in  VEC_W  port-B read data, valid 1 cycle after sp_en with sp_we=0
sp_en  out  1  port-B enable
sp_we  out  NUM_BANKS  port-B per-bank write enable
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a burst completes
done_is_wr  out  1  qualifies done: 1 = write burst, 0 = read burst

Behaviour:
- Reset values: all outputs 0. State IDLE, FIFO empty, in-flight flag 0, last_grant = WR (the first contention is won by RD).
- States: IDLE, RD, WR.
- IDLE arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - Grant cycle: assert the matching cmd_ready combinationally; latch row and len; update last_grant; go to RD or WR.
  - len == 0: no port-B access; pulse done (done_is_wr set per command) the cycle after acceptance; return to IDLE.
- RD issue:
  - Issue when rows_issued < len and (fifo_count + inflight < 2, or an rd_data handshake occurs this cycle).
  - On issue: sp_en=1, sp_we=0, sp_addr={cur_row,3'b000}; cur_row increments modulo 2^ROW_W (wraps 1023 -> 0).
  - inflight is set on issue; next cycle sp_dout is pushed into the FIFO.
- RD output:
  - rd_data and rd_data_valid come from the FIFO head.
  - Latency: command accepted at cycle T, first sp_en at T+1, rd_data_valid at T+3.
  - Sustained 1 row/cycle while rd_data_ready=1.
  - Backpressure never drops or duplicates data.
- RD completion: when all rows are issued, inflight=0, FIFO empty and the last handshake is done: done=1, done_is_wr=0, go to IDLE.
- WR:
  - wr_data_ready=1 in WR while rows remain.
  - On handshake, same cycle: sp_en=1, sp_we=wr_strb, sp_din=wr_data, sp_addr={cur_row,3'b000}; cur_row increments with wrap.
  - wr_strb=0 still consumes the row and advances cur_row.
  - After the last beat: done=1, done_is_wr=1, go to IDLE the next cycle.
- Port-B outputs (sp_en, sp_we, sp_addr, sp_din) are combinational from state and handshakes; sp_en=0 and sp_we=0 in all other cycles.
- cmd_ready is never asserted outside IDLE; commands arriving mid-burst wait.
- Reset mid-burst: immediate return to IDLE; FIFO and inflight cleared; the pending read return is discarded; no done pulse.

Optional Feature:
SPAD_SCHED_PERF_EN:
- Defined: adds 32-bit saturating counters, exposed on output ports perf_rd_rows, perf_wr_rows and perf_stall_cycles.
  - perf_rd_rows: rows read.
  - perf_wr_rows: rows written.
  - perf_stall_cycles: cycles in RD with rd_data_valid=1 and rd_data_ready=0, plus cycles in WR with wr_data_valid=0.
  - Cleared by reset.
- Undefined: the ports remain and are tied to 0; no counter logic.

Test Plan:
- Read row 5, len 4, rd_data_ready=1; rows preloaded with pattern row*0x11 -> sp_addr 40,48,56,64 on consecutive cycles; 4 vectors in order; done with done_is_wr=0 exactly once.
- Write row 1023, len 2, wr_strb=0xFF then 0x0F -> sp_addr 8184 then 0 (wrap); sp_we=FF then 0F; done_is_wr=1.
- Read len 6 with rd_data_ready toggled 1,0,0,1,... -> never >2 outstanding (FIFO + inflight); all 6 vectors delivered, none lost or duplicated.
- rd_cmd and wr_cmd valid in the same cycle out of reset -> RD granted first. Repeat after completion -> WR granted. Third contention -> RD.
- len=0 write -> no sp_en; done pulse 1 cycle after wr_cmd_ready.
- rst_n asserted during read burst row 2 of 8 -> busy=0, rd_data_valid=0; after release, a new len-1 read returns the correct row only.
